sync_fifo_flags: RTL and testbench

Single-clock, parametrised FIFO for buffering byte-wide or wider streams within one clock domain. It is the next-generation companion to the team's asynchronous FIFO and keeps the same push/pop/full/empty handshake. It adds:
- Fill-level output.
- Programmable almost-full and almost-empty thresholds.
- Sticky overflow and underflow error flags.
- A first-word-fall-through (FWFT) read mode, selected at elaboration.

---
 rtl/sync_fifo_flags.sv | 90 +++++++++
 tb/tb_sync_fifo_flags.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/sync_fifo_flags.sv
// Single-clock FIFO with fill level, programmable almost-full/almost-empty,
// sticky overflow/underflow flags and an elaboration-time FWFT read mode.
module sync_fifo_flags #(
  parameter int DEPTH    = 16,
  parameter int PTRWIDTH = 4,
  parameter int DWIDTH   = 8,
  parameter int FWFT     = 0
) (
  input  logic                clk,
  input  logic                reset_L,
  input  logic                push,
  input  logic [DWIDTH-1:0]   wdata,
  output logic                full,
  input  logic                pop,
  output logic [DWIDTH-1:0]   rdata,
  output logic                empty,
  output logic [PTRWIDTH:0]   count,
  input  logic [PTRWIDTH:0]   afull_thresh,
  input  logic [PTRWIDTH:0]   aempty_thresh,
  output logic                almost_full,
  output logic                almost_empty,
  output logic                overflow,
  output logic                underflow,
  input  logic                clr_err
);

  logic [DWIDTH-1:0]   mem [DEPTH];
  logic [PTRWIDTH:0]   wr_ptr;
  logic [PTRWIDTH:0]   rd_ptr;
  logic [PTRWIDTH-1:0] wr_addr;
  logic [PTRWIDTH-1:0] rd_addr;
  logic                push_ok;
  logic                pop_ok;

  assign wr_addr = wr_ptr[PTRWIDTH-1:0];
  assign rd_addr = rd_ptr[PTRWIDTH-1:0];

  // Extra wrap bit distinguishes full (wrap bits differ) from empty (identical).
  assign full  = (wr_ptr[PTRWIDTH] != rd_ptr[PTRWIDTH]) && (wr_addr == rd_addr);
  assign empty = (wr_ptr == rd_ptr);
  assign count = wr_ptr - rd_ptr;

  assign almost_full  = (count >= afull_thresh);
  assign almost_empty = (count <= aempty_thresh);

  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;

  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_addr] <= wdata;
  end

  // A new error in the same cycle as clr_err must survive the clear.
  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (push && full)  overflow <= 1'b1;
      else if (clr_err)  overflow <= 1'b0;
      if (pop && empty)  underflow <= 1'b1;
      else if (clr_err)  underflow <= 1'b0;
    end
  end

  generate
    if (FWFT != 0) begin : g_fwft
      assign rdata = empty ? '0 : mem[rd_addr];
    end else begin : g_reg_read
      logic [DWIDTH-1:0] rdata_p1;
      // Registered read stage: head word captured on the popping edge.
      always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L)    rdata_p1 <= '0;
        else if (pop_ok) rdata_p1 <= mem[rd_addr];
      end
      assign rdata = rdata_p1;
    end
  endgenerate

endmodule

// File: tb/tb_sync_fifo_flags.sv
// Bench for sync_fifo_flags: registered-read and FWFT instances driven in lockstep
// and compared against a queue-based reference model.
module tb_sync_fifo_flags;
  localparam int DEPTH = 16;
  localparam int PW    = 4;
  localparam int DW    = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset_L, push, pop, clr_err;
  logic [DW-1:0] wdata;
  logic [PW:0]   afth, aeth;

  logic          full0, empty0, af0, ae0, ov0, un0;
  logic [DW-1:0] rdata0;
  logic [PW:0]   count0;
  logic          full1, empty1, af1, ae1, ov1, un1;
  logic [DW-1:0] rdata1;
  logic [PW:0]   count1;

  sync_fifo_flags #(.DEPTH(DEPTH), .PTRWIDTH(PW), .DWIDTH(DW), .FWFT(0)) dut0 (
    .clk(clk), .reset_L(reset_L), .push(push), .wdata(wdata), .full(full0),
    .pop(pop), .rdata(rdata0), .empty(empty0), .count(count0),
    .afull_thresh(afth), .aempty_thresh(aeth), .almost_full(af0),
    .almost_empty(ae0), .overflow(ov0), .underflow(un0), .clr_err(clr_err)
  );

  sync_fifo_flags #(.DEPTH(DEPTH), .PTRWIDTH(PW), .DWIDTH(DW), .FWFT(1)) dut1 (
    .clk(clk), .reset_L(reset_L), .push(push), .wdata(wdata), .full(full1),
    .pop(pop), .rdata(rdata1), .empty(empty1), .count(count1),
    .afull_thresh(afth), .aempty_thresh(aeth), .almost_full(af1),
    .almost_empty(ae1), .overflow(ov1), .underflow(un1), .clr_err(clr_err)
  );

  // Reference model: contents as a queue, flags from its size.
  logic [DW-1:0] q[$];
  logic          m_ov, m_un;
  logic [DW-1:0] m_rd0;
  int vectors = 0;
  int miscompares = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    q.delete();
    m_ov  = 1'b0;
    m_un  = 1'b0;
    m_rd0 = '0;
  endtask

  task automatic model_edge();
    bit f, e;
    f = (q.size() == DEPTH);
    e = (q.size() == 0);
    if (push && f)    m_ov = 1'b1;
    else if (clr_err) m_ov = 1'b0;
    if (pop && e)     m_un = 1'b1;
    else if (clr_err) m_un = 1'b0;
    if (pop && !e)    m_rd0 = q.pop_front();
    if (push && !f)   q.push_back(wdata);
  endtask

  task automatic check_all();
    int sz;
    logic e_af, e_ae;
    sz   = q.size();
    e_af = (sz >= int'(afth));
    e_ae = (sz <= int'(aeth));
    check("d0 count", 32'(count0), 32'(sz));
    check("d0 full",  32'(full0),  32'(sz == DEPTH));
    check("d0 empty", 32'(empty0), 32'(sz == 0));
    check("d0 afull", 32'(af0),    32'(e_af));
    check("d0 aempty",32'(ae0),    32'(e_ae));
    check("d0 ovf",   32'(ov0),    32'(m_ov));
    check("d0 unf",   32'(un0),    32'(m_un));
    check("d0 rdata", 32'(rdata0), 32'(m_rd0));
    check("d1 count", 32'(count1), 32'(sz));
    check("d1 full",  32'(full1),  32'(sz == DEPTH));
    check("d1 empty", 32'(empty1), 32'(sz == 0));
    check("d1 afull", 32'(af1),    32'(e_af));
    check("d1 aempty",32'(ae1),    32'(e_ae));
    check("d1 ovf",   32'(ov1),    32'(m_ov));
    check("d1 unf",   32'(un1),    32'(m_un));
    if (sz > 0) check("d1 fwft rdata", 32'(rdata1), 32'(q[0]));
  endtask

  task automatic step(input bit pu, input logic [DW-1:0] wd, input bit po, input bit cl);
    push    = pu;
    wdata   = wd;
    pop     = po;
    clr_err = cl;
    @(posedge clk);
    model_edge();
    #1;
    check_all();
    @(negedge clk);
    push    = 1'b0;
    pop     = 1'b0;
    clr_err = 1'b0;
  endtask

  initial begin
    reset_L = 1'b0;
    push    = 1'b0;
    pop     = 1'b0;
    clr_err = 1'b0;
    wdata   = '0;
    afth    = 5'd12;
    aeth    = 5'd2;
    model_reset();
    #2;
    check_all();
    @(negedge clk);
    reset_L = 1'b1;

    // Fill to full then drain; registered rdata follows each pop by one edge.
    for (int i = 1; i <= 16; i++) step(1'b1, 8'(i), 1'b0, 1'b0);
    for (int i = 0; i < 16; i++)  step(1'b0, 8'h00, 1'b1, 1'b0);

    // Overflow on full, push+pop on full, clear, then verify contents survived.
    for (int i = 1; i <= 16; i++) step(1'b1, 8'(i), 1'b0, 1'b0);
    step(1'b1, 8'hAA, 1'b0, 1'b0);
    step(1'b1, 8'hBB, 1'b1, 1'b0);
    step(1'b0, 8'h00, 1'b0, 1'b1);
    for (int i = 0; i < 15; i++)  step(1'b0, 8'h00, 1'b1, 1'b0);

    // Underflow on empty with simultaneous push; set beats clear.
    step(1'b1, 8'h5A, 1'b1, 1'b0);
    step(1'b0, 8'h00, 1'b1, 1'b0);
    step(1'b0, 8'h00, 1'b1, 1'b1);
    step(1'b0, 8'h00, 1'b0, 1'b1);

    // Steady-state streaming across two pointer wraps.
    for (int i = 0; i < 3; i++)   step(1'b1, 8'hE0 + 8'(i), 1'b0, 1'b0);
    for (int i = 0; i < 40; i++)  step(1'b1, 8'(i), 1'b1, 1'b0);
    for (int i = 0; i < 3; i++)   step(1'b0, 8'h00, 1'b1, 1'b0);

    // FWFT: word visible one edge after push into empty; pop empties.
    step(1'b1, 8'h77, 1'b0, 1'b0);
    step(1'b0, 8'h00, 1'b1, 1'b0);

    // Threshold boundaries applied combinationally between edges.
    for (int i = 0; i < 9; i++)   step(1'b1, 8'h30 + 8'(i), 1'b0, 1'b0);
    afth = 5'd9;  aeth = 5'd9;  #1; check_all();
    afth = 5'd10; aeth = 5'd8;  #1; check_all();
    afth = 5'd0;  aeth = 5'd16; #1; check_all();
    afth = 5'd17; aeth = 5'd0;  #1; check_all();
    afth = 5'd12; aeth = 5'd2;  #1; check_all();

    // Asynchronous reset mid-stream with 9 entries stored.
    @(posedge clk);
    #2;
    reset_L = 1'b0;
    model_reset();
    #1;
    check_all();
    @(negedge clk);
    reset_L = 1'b1;

    // Randomised traffic with phase-biased push/pop rates and random thresholds.
    for (int blk = 0; blk < 12; blk++) begin
      int pw, pp;
      afth = 5'($urandom_range(0, 31));
      aeth = 5'($urandom_range(0, 31));
      pw   = $urandom_range(20, 90);
      pp   = 110 - pw;
      #1; check_all();
      for (int c = 0; c < 40; c++)
        step(($urandom % 100) < pw, 8'($urandom), ($urandom % 100) < pp,
             ($urandom % 16) == 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
